zapper_multi: RTL
=================

ZAPPER_MULTI -- requirements
Module: zapper_multi

Interface
REQ-001 SHALL have parameter NUM_GUNS, default 2, number of independent light-gun channels (1..4).
REQ-002 SHALL have parameter TRIG_PULL, default 830000, clocks trigger stays asserted per shot.
REQ-003 SHALL have parameter TRIG_COOL, default 2100000, clocks of post-shot lockout.
REQ-004 SHALL have parameter WIN, default 4, half-width in pixels of the light-sensing square.
REQ-005 SHALL have parameter MOUSE_CH, default 0, channel driven by the PS/2 mouse.
REQ-006 SHALL have clk  input  1  system clock.
REQ-007 SHALL have reset  input  1  reset; synchronous, active-high.
REQ-008 SHALL have ps2_mouse  input  25  {toggle, dy[7:0], dx[7:0], ctrl[7:0]}; ctrl[0] left button, ctrl[4]/ctrl[5] X/Y sign; bit 24 toggles per packet.
REQ-009 SHALL have analog  input  16*NUM_GUNS  per channel {y[7:0], x[7:0]}, two's complement.
REQ-010 SHALL have analog_trigger  input  NUM_GUNS  per-channel mapped trigger button.
REQ-011 SHALL have mode  input  NUM_GUNS  per channel: 0 mouse positioning, 1 analog positioning.
REQ-012 SHALL have cycle, scanline  input  9 each  current PPU pixel coordinates.
REQ-013 SHALL have color  input  6  current NES palette index.
REQ-014 SHALL have light  output  NUM_GUNS  per channel, active-low light sense.
REQ-015 SHALL have trigger  output  NUM_GUNS  per channel, active-high trigger.
REQ-016 SHALL have reticule  output  2*NUM_GUNS  per channel {offscreen, crosshair pixel}.

Function
REQ-017 Mouse packet SHALL be detected on any transition of ps2_mouse[24] (registered copy); one event per transition.
REQ-018 On packet with mode[MOUSE_CH]=0: pos += {sign,dx}>>>2 (x), pos -= {sign,dy}>>>2 (y), 10-bit signed, result clamped to 0..255.
REQ-019 Channel with mode=1 SHALL each clock load x = ax+128, y = v-(v>>4) where v = ay+128 (v=255 -> 240, v=0 -> 0); mouse deltas ignored for that channel.
REQ-020 Press sources per channel: analog_trigger[i] OR (i==MOUSE_CH and packet left button); press edge = source high while previously released.
REQ-021 Trigger FSM per channel: IDLE -> PULL on press edge; PULL (trigger=1) TRIG_PULL clocks -> COOL; COOL (trigger=0) TRIG_COOL clocks -> IDLE if source released else WAIT_REL; WAIT_REL -> IDLE on release.
REQ-022 Press edges in PULL, COOL or WAIT_REL SHALL be ignored; no queueing.
REQ-023 Offscreen SHALL be x>=254 or x<=1 or y>=224 or y<=8.
REQ-024 Crosshair bit SHALL be 1 when (scanline==y and |cycle-x|<=1) or (cycle==x and |scanline-y|<=1); registered, 1-cycle latency.
REQ-025 Sense hit when |cycle-x|<=WIN and |scanline-y|<=WIN and not offscreen.
REQ-026 On sense hit, light counter SHALL load by priority: color 0x20/0x30 -> 26 unconditionally; else (0x30..0x3D or 0x10) -> max(cnt,20); else (0x20..0x2D or 0x00) -> max(cnt,17); else unchanged.
REQ-027 Light counter SHALL decrement by 1 on each scanline change when nonzero; load wins over decrement in the same clock.
REQ-028 light[i] SHALL be 0 when counter>0, else 1.
REQ-029 Channels SHALL be fully independent; simultaneous events on several channels all take effect same clock.

Reset
REQ-030 On reset: positions 0, light counters 0 (light=all 1), FSMs IDLE (trigger=0), reticule 0, press latches released, packet toggle copy loaded from input.
REQ-031 Reset mid-shot SHALL drop trigger next clock; a held button after reset SHALL not fire until released.

Verification
REQ-032 Mouse ch0 at (100,100), packet dx=+40, dy=+8 -> pos (110,98); dx=-128 from x=10 -> x=0.
REQ-033 mode[1]=1, analog ch1 = {y=127,x=-128} -> ch1 pos (0,240), reticule[3]=1.
REQ-034 Press ch0 at t0, TRIG_PULL=10, TRIG_COOL=20 -> trigger[0]=1 for 10 clocks, 0 for 20, held button stays WAIT_REL until release; re-press during COOL ignored.
REQ-035 Gun at (128,120), color 0x30 at (130,118) -> light=0; after 26 scanline changes without hit -> light=1; color 0x16 hit -> unchanged.
REQ-036 Two guns both pressed same clock plus reset asserted 5 clocks into PULL -> both triggers 0 next clock, no fire until both released.

Source files
------------

// File: rtl/zapper_multi.sv
// rtl/zapper_multi.sv - multi-channel NES Zapper light-gun emulation (mouse/analog aim, trigger timing, light sense)
module zapper_multi #(
  parameter int NUM_GUNS  = 2,
  parameter int TRIG_PULL = 830000,
  parameter int TRIG_COOL = 2100000,
  parameter int WIN       = 4,
  parameter int MOUSE_CH  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [24:0]            ps2_mouse,
  input  logic [16*NUM_GUNS-1:0] analog,
  input  logic [NUM_GUNS-1:0]    analog_trigger,
  input  logic [NUM_GUNS-1:0]    mode,
  input  logic [8:0]             cycle,
  input  logic [8:0]             scanline,
  input  logic [5:0]             color,
  output logic [NUM_GUNS-1:0]    light,
  output logic [NUM_GUNS-1:0]    trigger,
  output logic [2*NUM_GUNS-1:0]  reticule
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PULL = 2'd1;
  localparam logic [1:0] S_COOL = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  localparam int TMAX = (TRIG_PULL > TRIG_COOL) ? TRIG_PULL : TRIG_COOL;
  localparam int CW   = $clog2(TMAX + 1);
  localparam logic signed [9:0] WINS = 10'(WIN);

  logic       r_tog;
  logic       r_mbtn;
  logic [8:0] r_last_scan;
  logic       w_packet;
  logic       w_scan_chg;
  logic signed [8:0] w_sdx, w_sdy, w_qdx, w_qdy;
  logic signed [9:0] w_ddx, w_ddy;
  logic       w_unused;

  assign w_packet   = ps2_mouse[24] ^ r_tog;
  assign w_scan_chg = (scanline != r_last_scan);
  assign w_sdx      = {ps2_mouse[4], ps2_mouse[15:8]};
  assign w_sdy      = {ps2_mouse[5], ps2_mouse[23:16]};
  assign w_qdx      = w_sdx >>> 2;
  assign w_qdy      = w_sdy >>> 2;
  assign w_ddx      = {w_qdx[8], w_qdx};
  assign w_ddy      = {w_qdy[8], w_qdy};
  assign w_unused   = ^{ps2_mouse[7:6], ps2_mouse[3:1]};

  // Packet toggle tracking, latched mouse button and scanline-change detector
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tog       <= ps2_mouse[24];
      r_mbtn      <= 1'b0;
      r_last_scan <= scanline;
    end else begin
      r_tog       <= ps2_mouse[24];
      r_last_scan <= scanline;
      if (w_packet) r_mbtn <= ps2_mouse[0];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GUNS; gi++) begin : g_ch
      localparam bit IS_M = (gi == MOUSE_CH);

      logic [7:0]    r_x, r_y;
      logic [1:0]    r_st;
      logic [CW-1:0] r_cnt;
      logic          r_prev;
      logic [4:0]    r_lcnt;
      logic [1:0]    r_ret;
      logic [4:0]    w_lcnt_nx;
      logic [7:0]    w_ax, w_v, w_mx, w_my;
      logic signed [9:0] w_nx, w_ny, w_dc, w_ds;
      logic          w_src, w_off, w_xh, w_hit;

      assign w_ax  = analog[16*gi +: 8];
      assign w_v   = analog[16*gi+8 +: 8] ^ 8'h80;
      assign w_nx  = $signed({2'b00, r_x}) + w_ddx;
      assign w_ny  = $signed({2'b00, r_y}) - w_ddy;
      assign w_mx  = w_nx[9] ? 8'd0 : (w_nx[8] ? 8'hFF : w_nx[7:0]);
      assign w_my  = w_ny[9] ? 8'd0 : (w_ny[8] ? 8'hFF : w_ny[7:0]);

      assign w_dc  = $signed({1'b0, cycle}) - $signed({2'b00, r_x});
      assign w_ds  = $signed({1'b0, scanline}) - $signed({2'b00, r_y});
      assign w_off = (r_x >= 8'd254) || (r_x <= 8'd1) || (r_y >= 8'd224) || (r_y <= 8'd8);
      assign w_xh  = ((w_ds == 10'sd0) && (w_dc >= -10'sd1) && (w_dc <= 10'sd1)) ||
                     ((w_dc == 10'sd0) && (w_ds >= -10'sd1) && (w_ds <= 10'sd1));
      assign w_hit = (w_dc >= -WINS) && (w_dc <= WINS) &&
                     (w_ds >= -WINS) && (w_ds <= WINS) && !w_off;

      assign w_src = analog_trigger[gi] | (IS_M & r_mbtn);

      // Aim position: analog mode reloads every clock, mouse mode moves on packets
      always_ff @(posedge clk) begin
        if (reset) begin
          r_x <= 8'd0;
          r_y <= 8'd0;
        end else if (mode[gi]) begin
          r_x <= w_ax ^ 8'h80;
          r_y <= w_v - {4'b0000, w_v[7:4]};
        end else if (IS_M && w_packet) begin
          r_x <= w_mx;
          r_y <= w_my;
        end
      end

      // Trigger shot timing; r_prev resets high so a button held through reset must be released first
      always_ff @(posedge clk) begin
        if (reset) begin
          r_st   <= S_IDLE;
          r_cnt  <= '0;
          r_prev <= 1'b1;
        end else begin
          r_prev <= w_src;
          case (r_st)
            S_IDLE: begin
              if (w_src && !r_prev) begin
                r_st  <= S_PULL;
                r_cnt <= '0;
              end
            end
            S_PULL: begin
              if (r_cnt == CW'(TRIG_PULL - 1)) begin
                r_st  <= S_COOL;
                r_cnt <= '0;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            S_COOL: begin
              if (r_cnt == CW'(TRIG_COOL - 1)) begin
                r_st  <= w_src ? S_WAIT : S_IDLE;
                r_cnt <= '0;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end
            default: begin
              if (!w_src) r_st <= S_IDLE;
            end
          endcase
        end
      end

      // Light counter next value: brightness-class load beats scanline decay
      always_comb begin
        w_lcnt_nx = r_lcnt;
        if (w_hit && (color == 6'h20 || color == 6'h30)) begin
          w_lcnt_nx = 5'd26;
        end else if (w_hit && ((color >= 6'h30 && color <= 6'h3D) || color == 6'h10)) begin
          w_lcnt_nx = (r_lcnt > 5'd20) ? r_lcnt : 5'd20;
        end else if (w_hit && ((color >= 6'h20 && color <= 6'h2D) || color == 6'h00)) begin
          w_lcnt_nx = (r_lcnt > 5'd17) ? r_lcnt : 5'd17;
        end else if (w_scan_chg && r_lcnt != 5'd0) begin
          w_lcnt_nx = r_lcnt - 5'd1;
        end
      end

      // Light counter and registered reticule overlay
      always_ff @(posedge clk) begin
        if (reset) begin
          r_lcnt <= 5'd0;
          r_ret  <= 2'b00;
        end else begin
          r_lcnt <= w_lcnt_nx;
          r_ret  <= {w_off, w_xh};
        end
      end

      assign light[gi]           = (r_lcnt == 5'd0);
      assign trigger[gi]         = (r_st == S_PULL);
      assign reticule[2*gi +: 2] = r_ret;
    end
  endgenerate

endmodule
